// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and IR capture value.
package jtag_pkg;

    // Standard 1149.1 four-bit state encoding.
    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_e;

    localparam logic [1:0] EXTEST = 2'b00;
    localparam logic [1:0] SAMPLE = 2'b01;
    localparam logic [1:0] INTEST = 2'b10;
    localparam logic [1:0] BYPASS = 2'b11;

    // The two LSBs captured into the IR are always 01.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// Pin-side and CUT-side signals of the TAP controller, minus TCK/TRST.
interface jtag_tap_controller_if #(
    parameter int IR_WIDTH = 2
);
    logic                TMS;
    logic                TDI;
    logic                MUX_OUT;
    logic                TDO;
    logic                TDO_EN;
    logic                ShiftDR;
    logic                CaptureDR;
    logic                ClockDR;
    logic                UpdateDR;
    logic                Mode;
    logic                MUX_OUT_SEL;
    logic [IR_WIDTH-1:0] IR_OUT;

    modport slave (
        input  TMS, TDI, MUX_OUT,
        output TDO, TDO_EN, ShiftDR, CaptureDR, ClockDR, UpdateDR,
               Mode, MUX_OUT_SEL, IR_OUT
    );

    modport master (
        output TMS, TDI, MUX_OUT,
        input  TDO, TDO_EN, ShiftDR, CaptureDR, ClockDR, UpdateDR,
               Mode, MUX_OUT_SEL, IR_OUT
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: TMS-driven next state plus state register.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       tms_i,
    output tap_state_e state_o,
    output tap_state_e stateNext_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register; TRST wins over whatever TMS asks for.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TMS transition table.
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state_o     = state_q;
    assign stateNext_o = state_d;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller top: IR, instruction decode, DR control and clock gating, TDO.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH   = 2,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(jtag_pkg::IR_CAPTURE)
) (
    input  logic                  TCK,
    input  logic                  TRST,
    jtag_tap_controller_if.slave  bus
);

    tap_state_e          tapState;
    tap_state_e          tapStateNext;
    logic [IR_WIDTH-1:0] irShift_q;
    logic [IR_WIDTH-1:0] irShift_d;
    logic [IR_WIDTH-1:0] irOut_q;
    logic                shiftDr_q;
    logic                captureDr_q;
    logic                ckdrEn_q;
    logic                updEn_q;
    logic                tdo_q;
    logic                tdoEn_q;
    logic                mode;
    logic                muxOutSel;

    jtag_tap_fsm tapFsm (
        .TCK         (TCK),
        .TRST        (TRST),
        .tms_i       (bus.TMS),
        .state_o     (tapState),
        .stateNext_o (tapStateNext)
    );

    // IR shift stage: capture the fixed pattern, shift right with TDI at the MSB, else hold.
    always_comb begin
        irShift_d = irShift_q;
        case (tapState)
            CAP_IR:  irShift_d = IR_CAPTURE;
            SH_IR:   irShift_d = {bus.TDI, irShift_q[IR_WIDTH-1:1]};
            default: irShift_d = irShift_q;
        endcase
    end

    // Rising-edge state: IR shift stage plus ShiftDR/CaptureDR, registered from the next state.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            irShift_q   <= '1;
            shiftDr_q   <= 1'b0;
            captureDr_q <= 1'b0;
        end else begin
            irShift_q   <= irShift_d;
            shiftDr_q   <= (tapStateNext == SH_DR);
            captureDr_q <= (tapStateNext == CAP_DR);
        end
    end

    // Falling-edge state: gate enables, TDO, and the IR update (TLR restores BYPASS).
    always_ff @(negedge TCK) begin
        ckdrEn_q <= (tapState == CAP_DR) || (tapState == SH_DR);
        updEn_q  <= (tapState == UPD_DR);
        tdoEn_q  <= (tapState == SH_IR) || (tapState == SH_DR);
        if (tapState == SH_IR) begin
            tdo_q <= irShift_q[0];
        end else if (tapState == SH_DR) begin
            tdo_q <= bus.MUX_OUT;
        end else begin
            tdo_q <= 1'b0;
        end
        if (tapState == TLR) begin
            irOut_q <= '1;
        end else if (tapState == UPD_IR) begin
            irOut_q <= irShift_q;
        end
    end

    // Instruction decode from the updated IR only; unknown codes behave as BYPASS.
    always_comb begin
        mode      = 1'b0;
        muxOutSel = 1'b0;
        case (irOut_q)
            IR_WIDTH'(EXTEST): begin
                mode      = 1'b1;
                muxOutSel = 1'b1;
            end
            IR_WIDTH'(SAMPLE): begin
                mode      = 1'b0;
                muxOutSel = 1'b1;
            end
            IR_WIDTH'(INTEST): begin
                mode      = 1'b1;
                muxOutSel = 1'b1;
            end
            default: begin
                mode      = 1'b0;
                muxOutSel = 1'b0;
            end
        endcase
    end

    assign bus.ClockDR     = TCK | ~ckdrEn_q;
    assign bus.UpdateDR    = ~TCK & updEn_q;
    assign bus.ShiftDR     = shiftDr_q;
    assign bus.CaptureDR   = captureDr_q;
    assign bus.TDO         = tdo_q;
    assign bus.TDO_EN      = tdoEn_q;
    assign bus.IR_OUT      = irOut_q;
    assign bus.Mode        = mode;
    assign bus.MUX_OUT_SEL = muxOutSel;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for the TAP controller with a bypass-register model on the DR side.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    logic tck  = 1'b0;
    logic trst = 1'b1;

    jtag_tap_controller_if #(.IR_WIDTH(2)) bus ();

    jtag_tap_controller #(.IR_WIDTH(2)) dut (
        .TCK  (tck),
        .TRST (trst),
        .bus  (bus)
    );

    int vectorCount   = 0;
    int missCount     = 0;
    int clockDrEdges  = 0;
    int shiftCycles   = 0;
    int captureCycles = 0;
    int updPulses     = 0;

    logic lowClockDr = 1'b1;
    logic lowShift   = 1'b0;
    logic lowTdi     = 1'b0;
    logic bypassReg  = 1'b0;

    // Paths from TLR to every state, TMS bits applied LSB first.
    tap_state_e pathTarget[16] = '{TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
                                   UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR};
    logic [7:0] pathBits[16]  = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010, 8'b101010,
                                  8'b11010, 8'b110, 8'b0110, 8'b00110, 8'b10110, 8'b010110,
                                  8'b1010110, 8'b110110};
    int pathLen[16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    always #5 tck = ~tck;

    assign bus.MUX_OUT = bypassReg;

    // Mid-low-phase sampling of the DR-side controls and per-cycle activity counters.
    always @(negedge tck) begin
        #3;
        lowClockDr    = bus.ClockDR;
        lowShift      = bus.ShiftDR;
        lowTdi        = bus.TDI;
        shiftCycles   += int'(bus.ShiftDR);
        captureCycles += int'(bus.CaptureDR);
        updPulses     += int'(bus.UpdateDR);
    end

    // ClockDR low in the low phase means it rises with TCK; the bypass register clocks then.
    always @(posedge tck) begin
        if (lowClockDr === 1'b0) begin
            clockDrEdges++;
            bypassReg = lowShift ? lowTdi : 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitRise();
        @(posedge tck);
        #1;
    endtask

    task automatic waitFall();
        @(negedge tck);
        #1;
    endtask

    task automatic applyStimulus(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        waitRise();
        waitFall();
    endtask

    task automatic applyReset();
        trst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        trst = 1'b0;
    endtask

    task automatic loadIr(input logic [1:0] op, input logic modeBefore, input logic selBefore,
                          input logic modeAfter, input logic selAfter);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ld_capture_tdo", 8'(bus.TDO), 8'd1);
        applyStimulus(1'b0, op[0]);
        applyStimulus(1'b1, op[1]);
        bus.TMS = 1'b1;
        waitRise();
        checkOutput("ld_state_upd_ir", 8'(dut.tapState), 8'(UPD_IR));
        checkOutput("ld_mode_before", 8'(bus.Mode), 8'(modeBefore));
        checkOutput("ld_sel_before", 8'(bus.MUX_OUT_SEL), 8'(selBefore));
        waitFall();
        checkOutput("ld_ir_out", 8'(bus.IR_OUT), 8'(op));
        checkOutput("ld_mode_after", 8'(bus.Mode), 8'(modeAfter));
        checkOutput("ld_sel_after", 8'(bus.MUX_OUT_SEL), 8'(selAfter));
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        bus.TMS = 1'b0;
        bus.TDI = 1'b0;

        // Reset outputs.
        applyReset();
        checkOutput("rst_state", 8'(dut.tapState), 8'(TLR));
        checkOutput("rst_tdo", 8'(bus.TDO), 8'd0);
        checkOutput("rst_tdo_en", 8'(bus.TDO_EN), 8'd0);
        checkOutput("rst_shiftdr", 8'(bus.ShiftDR), 8'd0);
        checkOutput("rst_capturedr", 8'(bus.CaptureDR), 8'd0);
        checkOutput("rst_clockdr", 8'(bus.ClockDR), 8'd1);
        checkOutput("rst_updatedr", 8'(bus.UpdateDR), 8'd0);
        checkOutput("rst_mode", 8'(bus.Mode), 8'd0);
        checkOutput("rst_sel", 8'(bus.MUX_OUT_SEL), 8'd0);
        checkOutput("rst_ir_out", 8'(bus.IR_OUT), 8'b11);

        // Five TMS=1 cycles from every state return to TLR.
        for (int s = 0; s < 16; s++) begin
            applyReset();
            for (int b = 0; b < pathLen[s]; b++) begin
                applyStimulus(pathBits[s][b], 1'b0);
            end
            checkOutput($sformatf("walk_to_%0d", s), 8'(dut.tapState), 8'(pathTarget[s]));
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b1, 1'b0);
            end
            checkOutput($sformatf("tms5_from_%0d", s), 8'(dut.tapState), 8'(TLR));
        end

        // TMS 0,1,1,0,0 walk into SH_IR, then load EXTEST.
        applyReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("walk_rti", 8'(dut.tapState), 8'(RTI));
        applyStimulus(1'b1, 1'b0);
        checkOutput("walk_sel_dr", 8'(dut.tapState), 8'(SEL_DR));
        applyStimulus(1'b1, 1'b0);
        checkOutput("walk_sel_ir", 8'(dut.tapState), 8'(SEL_IR));
        applyStimulus(1'b0, 1'b0);
        checkOutput("walk_cap_ir", 8'(dut.tapState), 8'(CAP_IR));
        applyStimulus(1'b0, 1'b0);
        checkOutput("walk_sh_ir", 8'(dut.tapState), 8'(SH_IR));
        checkOutput("extest_tdo0", 8'(bus.TDO), 8'd1);
        checkOutput("extest_tdo_en0", 8'(bus.TDO_EN), 8'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("extest_tdo1", 8'(bus.TDO), 8'd0);
        checkOutput("extest_tdo_en1", 8'(bus.TDO_EN), 8'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("extest_ex1_ir", 8'(dut.tapState), 8'(EX1_IR));
        checkOutput("extest_tdo_en_off", 8'(bus.TDO_EN), 8'd0);
        bus.TMS = 1'b1;
        waitRise();
        checkOutput("extest_ir_hold", 8'(bus.IR_OUT), 8'b11);
        waitFall();
        checkOutput("extest_ir_out", 8'(bus.IR_OUT), 8'b00);
        checkOutput("extest_mode", 8'(bus.Mode), 8'd1);
        checkOutput("extest_sel", 8'(bus.MUX_OUT_SEL), 8'd1);
        applyStimulus(1'b0, 1'b0);

        // TRST from SH_DR.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("trst_pre_state", 8'(dut.tapState), 8'(SH_DR));
        trst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        trst = 1'b0;
        checkOutput("trst_state", 8'(dut.tapState), 8'(TLR));
        checkOutput("trst_ir_out", 8'(bus.IR_OUT), 8'b11);
        checkOutput("trst_sel", 8'(bus.MUX_OUT_SEL), 8'd0);
        checkOutput("trst_mode", 8'(bus.Mode), 8'd0);
        checkOutput("trst_tdo_en", 8'(bus.TDO_EN), 8'd0);
        checkOutput("trst_clockdr", 8'(bus.ClockDR), 8'd1);

        // BYPASS: capture then four shifts of 1,0,1,1.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        clockDrEdges  = 0;
        shiftCycles   = 0;
        captureCycles = 0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("byp_capturedr", 8'(bus.CaptureDR), 8'd1);
        checkOutput("byp_shiftdr_cap", 8'(bus.ShiftDR), 8'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("byp_tdo_captured", 8'(bus.TDO), 8'd0);
        checkOutput("byp_tdo_en", 8'(bus.TDO_EN), 8'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("byp_tdo_d1", 8'(bus.TDO), 8'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("byp_tdo_d2", 8'(bus.TDO), 8'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("byp_tdo_d3", 8'(bus.TDO), 8'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("byp_ex1_state", 8'(dut.tapState), 8'(EX1_DR));
        checkOutput("byp_tdo_en_off", 8'(bus.TDO_EN), 8'd0);
        checkOutput("byp_clockdr_edges", 8'(clockDrEdges), 8'd5);
        checkOutput("byp_capture_cycles", 8'(captureCycles), 8'd1);
        checkOutput("byp_shift_cycles", 8'(shiftCycles), 8'd4);

        // Pause and resume, then a single UpdateDR pulse.
        updPulses = 0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pause_state", 8'(dut.tapState), 8'(PA_DR));
        checkOutput("pause_clockdr_high", 8'(bus.ClockDR), 8'd1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("resume_state", 8'(dut.tapState), 8'(SH_DR));
        checkOutput("resume_tdo", 8'(bus.TDO), 8'd1);
        checkOutput("pause_no_edges", 8'(clockDrEdges), 8'd5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resume_edges", 8'(clockDrEdges), 8'd6);
        bus.TMS = 1'b1;
        waitRise();
        checkOutput("upd_state", 8'(dut.tapState), 8'(UPD_DR));
        checkOutput("upd_high_phase", 8'(bus.UpdateDR), 8'd0);
        waitFall();
        checkOutput("upd_low_phase", 8'(bus.UpdateDR), 8'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("upd_after", 8'(bus.UpdateDR), 8'd0);
        checkOutput("upd_pulse_count", 8'(updPulses), 8'd1);
        checkOutput("upd_edges", 8'(clockDrEdges), 8'd6);

        // INTEST then BYPASS, decode changing only at the UPD_IR falling edge.
        loadIr(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        loadIr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 TAP controller with instruction register and decoder.
- Sequences the boundary-scan data path (BSC chain, bypass register, output mux) of a JTAG-ready CUT.
- Converts the TCK/TMS/TDI pin protocol into ShiftDR, ClockDR, UpdateDR, CaptureDR, Mode and MUX_OUT_SEL, and returns the selected serial data on TDO.
- Sits between the chip's test pins and the JTAG-ready CUT wrapper.

Parameters:
- IR_WIDTH, 2, instruction register length in bits (minimum 2).
- IR_CAPTURE, 2'b01, value loaded into the IR shift stage in CAPTURE_IR; LSBs fixed to 01 per 1149.1.

Ports:
- TCK  input  1  test clock; the only clock. Rising edge: FSM and IR shift. Falling edge: TDO and gate enables.
- TRST  input  1  synchronous, active-high reset, sampled on rising TCK.
- TMS  input  1  test mode select, sampled on rising TCK.
- TDI  input  1  serial data in; feeds the IR shift stage and passes through to the DR chain.
- MUX_OUT  input  1  serial data returned from the DR side (BSC chain or bypass register).
- TDO  output  1  serial data out.
- TDO_EN  output  1  high while TDO is driving valid data.
- ShiftDR  output  1  shift/capture select for the BSCs.
- CaptureDR  output  1  capture select for the bypass register.
- ClockDR  output  1  gated DR clock.
- UpdateDR  output  1  gated DR update clock.
- Mode  output  1  BSC mode: 1 = test data drives the CUT.
- MUX_OUT_SEL  output  1  DR select: 1 = BSC chain, 0 = bypass register.
- IR_OUT  output  IR_WIDTH  current (updated) instruction, for debug.

Behaviour:
- FSM has the 16 standard states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the matching IR states (SEL_IR ... UPD_IR).
  - Transitions follow the 1149.1 TMS table and occur on rising TCK.
  - Five consecutive TMS=1 cycles reach TLR from any state.
- TRST=1 at a rising edge forces TLR and IR=all-ones (BYPASS), overriding TMS. This holds mid-shift; a partially shifted IR is discarded.
- Outputs after reset or while in TLR:
  - TDO=0, TDO_EN=0.
  - ShiftDR=0, CaptureDR=0.
  - ClockDR=1 (idle high), UpdateDR=0.
  - Mode=0, MUX_OUT_SEL=0, IR_OUT=all-ones.
- Instruction decode (IR_WIDTH=2):
  - 00 EXTEST: Mode=1, MUX_OUT_SEL=1.
  - 01 SAMPLE/PRELOAD: Mode=0, MUX_OUT_SEL=1.
  - 10 INTEST: Mode=1, MUX_OUT_SEL=1.
  - 11 BYPASS: Mode=0, MUX_OUT_SEL=0.
  - Any code not listed decodes as BYPASS.
  - Decode uses IR_OUT only, so it changes only in UPD_IR or on reset.
- IR operation:
  - CAP_IR: the shift stage loads IR_CAPTURE.
  - SH_IR: each rising TCK shifts right, TDI enters the MSB.
  - UPD_IR: the shift stage is copied to IR_OUT on falling TCK.
  - PA_IR and EX1/EX2_IR hold the shift stage.
- DR control:
  - ShiftDR=1 is registered and high exactly while the state is SH_DR.
  - CaptureDR=1 is registered and high exactly while the state is CAP_DR.
  - ClockDR = TCK OR NOT ckdr_en, where ckdr_en is registered on falling TCK and is high in CAP_DR or SH_DR.
    - Result: exactly one ClockDR rising edge per TCK spent in CAP_DR/SH_DR.
    - No edges in PA_DR or EX states.
  - UpdateDR = NOT TCK AND upd_en, where upd_en is registered on falling TCK and is high in UPD_DR.
    - Result: one high pulse during the low half of the UPD_DR cycle.
  - Enables are registered on the falling edge so the clock gating is glitch-free.
- TDO is registered on falling TCK:
  - SH_IR: TDO = IR shift stage bit 0, TDO_EN=1.
  - SH_DR: TDO = MUX_OUT, TDO_EN=1.
  - All other states: TDO_EN=0 and TDO holds 0.
- Latency:
  - A TDI bit sampled on rising edge k appears on TDO at falling edge k + IR_WIDTH - 1 (IR path).
  - On the DR path, TDO follows the DR chain length.
- Simultaneous events:
  - TRST has priority over TMS.
  - SH_DR entered directly from CAP_DR: capture happens first, then the first shift on the next ClockDR edge.

Decomposition:
- Shared package jtag_pkg holds:
  - the TAP state encoding (4-bit, 16 named constants);
  - the instruction opcodes EXTEST, SAMPLE, INTEST, BYPASS;
  - IR_CAPTURE.
- One sub-module, jtag_tap_fsm: pure next-state logic plus the state register, driven by TMS and TRST.
- IR, decode and clock gating live in the top level.

Test Plan:
- TRST=1 for 1 cycle from SH_DR → state TLR, IR_OUT=11, MUX_OUT_SEL=0, Mode=0, TDO_EN=0, ClockDR=1.
- TMS=1 ×5 from each of the 16 states (TRST held 0) → TLR reached on the 5th edge or earlier; TMS 0,1,1,0,0 then walks TLR→RTI→SEL_DR→SEL_IR→CAP_IR→SH_IR.
- Load EXTEST: shift TDI bits 0,0 through SH_IR then UPD_IR → TDO emits 1,0 (captured 01, LSB first); IR_OUT=00, Mode=1, MUX_OUT_SEL=1.
- With BYPASS loaded: CAP_DR, then 4 SH_DR cycles with MUX_OUT tied to the bypass register → exactly 5 ClockDR rising edges; CaptureDR high 1 cycle; ShiftDR high 4 cycles; TDO shows TDI delayed by one bit.
- SH_DR→EX1_DR→PA_DR ×3→EX2_DR→SH_DR → no ClockDR edges in PA/EX states; shift resumes without bit loss; UPD_DR gives a single UpdateDR pulse in the TCK-low phase.
- Load opcode 10 (INTEST), then opcode 11 → Mode 1→0 and MUX_OUT_SEL 1→0, changing only at the UPD_IR falling edge.
